// File: rtl/biu_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : biu_ifetch
//  Brief    : Instruction-fetch bus interface; runs ICU single-word and
//             critical-word-first line-fill requests as word beats.
//  Revision : 1.0
// ============================================================================
module biu_ifetch (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        icu_req,
    input  logic [31:0] icu_biu_addr,
    input  logic [3:0]  icu_type,
    input  logic [1:0]  icu_size,
    output logic [31:0] biu_data,
    output logic [1:0]  biu_icu_ack,
    output logic        pj_req,
    output logic [31:0] pj_addr,
    output logic [3:0]  pj_type,
    output logic [1:0]  pj_size,
    input  logic        pj_ack,
    input  logic [31:0] pj_data_in,
    input  logic        pj_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_REL  = 2'd2
    } state_t;

    localparam logic [1:0] c_ACK_NONE = 2'b00;
    localparam logic [1:0] c_ACK_OK   = 2'b01;
    localparam logic [1:0] c_ACK_ERR  = 2'b10;

    state_t      r_state, w_state_nx;
    logic [29:0] r_word, w_word_nx;      // latched word address (byte addr [31:2])
    logic [1:0]  r_cnt, w_cnt_nx;
    logic [1:0]  r_rem, w_rem_nx;
    logic        r_pj_req, w_pj_req_nx;
    logic [31:0] r_pj_addr, w_pj_addr_nx;
    logic [3:0]  r_pj_type, w_pj_type_nx;
    logic [1:0]  r_ack, w_ack_nx;
    logic [31:0] r_data, w_data_nx;
    logic [1:0]  w_next_ofs;
    logic        w_unused;

    assign w_unused   = ^icu_biu_addr[1:0];
    // Offset of the following beat, wrapping inside the 16-byte line
    assign w_next_ofs = r_word[1:0] + r_cnt + 2'd1;

    always_comb begin
        w_state_nx   = r_state;
        w_word_nx    = r_word;
        w_cnt_nx     = r_cnt;
        w_rem_nx     = r_rem;
        w_pj_req_nx  = r_pj_req;
        w_pj_addr_nx = r_pj_addr;
        w_pj_type_nx = r_pj_type;
        w_ack_nx     = c_ACK_NONE;
        w_data_nx    = r_data;
        case (r_state)
            S_IDLE: begin
                if (icu_req) begin
                    w_state_nx   = S_BUSY;
                    w_word_nx    = icu_biu_addr[31:2];
                    w_cnt_nx     = 2'd0;
                    w_rem_nx     = (icu_size == 2'b11) ? 2'd3 : 2'd0;
                    w_pj_req_nx  = 1'b1;
                    w_pj_addr_nx = {icu_biu_addr[31:2], 2'b00};
                    w_pj_type_nx = icu_type;
                end
            end
            S_BUSY: begin
                if (pj_ack) begin
                    if (pj_err) begin
                        w_ack_nx    = c_ACK_ERR;
                        w_data_nx   = 32'd0;
                        w_pj_req_nx = 1'b0;
                        w_state_nx  = S_REL;
                    end else begin
                        w_ack_nx  = c_ACK_OK;
                        w_data_nx = pj_data_in;
                        if (r_rem == 2'd0) begin
                            w_pj_req_nx = 1'b0;
                            w_state_nx  = S_REL;
                        end else begin
                            w_cnt_nx     = r_cnt + 2'd1;
                            w_rem_nx     = r_rem - 2'd1;
                            w_pj_addr_nx = {r_word[29:2], w_next_ofs, 2'b00};
                        end
                    end
                end
            end
            S_REL: begin
                // Wait for the ICU to drop its request so a stale level is not re-issued
                if (!icu_req) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx  = S_IDLE;
                w_pj_req_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state   <= S_IDLE;
            r_word    <= 30'd0;
            r_cnt     <= 2'd0;
            r_rem     <= 2'd0;
            r_pj_req  <= 1'b0;
            r_pj_addr <= 32'd0;
            r_pj_type <= 4'd0;
            r_ack     <= c_ACK_NONE;
            r_data    <= 32'd0;
        end else begin
            r_state   <= w_state_nx;
            r_word    <= w_word_nx;
            r_cnt     <= w_cnt_nx;
            r_rem     <= w_rem_nx;
            r_pj_req  <= w_pj_req_nx;
            r_pj_addr <= w_pj_addr_nx;
            r_pj_type <= w_pj_type_nx;
            r_ack     <= w_ack_nx;
            r_data    <= w_data_nx;
        end
    end

    assign pj_req      = r_pj_req;
    assign pj_addr     = r_pj_addr;
    assign pj_type     = r_pj_type;
    assign pj_size     = 2'b10;
    assign biu_icu_ack = r_ack;
    assign biu_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_biu_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_biu_ifetch
//  Brief    : Directed self-checking bench for biu_ifetch.
//  Revision : 1.0
// ============================================================================
module tb_biu_ifetch;

    logic        clk;
    logic        reset_l;
    logic        icu_req;
    logic [31:0] icu_biu_addr;
    logic [3:0]  icu_type;
    logic [1:0]  icu_size;
    logic [31:0] biu_data;
    logic [1:0]  biu_icu_ack;
    logic        pj_req;
    logic [31:0] pj_addr;
    logic [3:0]  pj_type;
    logic [1:0]  pj_size;
    logic        pj_ack;
    logic [31:0] pj_data_in;
    logic        pj_err;

    int tests_run;
    int tests_failed;

    biu_ifetch dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .icu_req      (icu_req),
        .icu_biu_addr (icu_biu_addr),
        .icu_type     (icu_type),
        .icu_size     (icu_size),
        .biu_data     (biu_data),
        .biu_icu_ack  (biu_icu_ack),
        .pj_req       (pj_req),
        .pj_addr      (pj_addr),
        .pj_type      (pj_type),
        .pj_size      (pj_size),
        .pj_ack       (pj_ack),
        .pj_data_in   (pj_data_in),
        .pj_err       (pj_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pj_req"},  {31'd0, pj_req}, 32'd0);
        check({tag, " pj_addr"}, pj_addr, 32'd0);
        check({tag, " pj_type"}, {28'd0, pj_type}, 32'd0);
        check({tag, " pj_size"}, {30'd0, pj_size}, 32'd2);
        check({tag, " ack"},     {30'd0, biu_icu_ack}, 32'd0);
        check({tag, " data"},    biu_data, 32'd0);
    endtask

    logic [31:0] exp_addr [4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_l      = 1'b0;
        icu_req      = 1'b0;
        icu_biu_addr = 32'd0;
        icu_type     = 4'd0;
        icu_size     = 2'b10;
        pj_ack       = 1'b0;
        pj_data_in   = 32'd0;
        pj_err       = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset_l = 1'b1;
        tick();
        check("idle no req", {31'd0, pj_req}, 32'd0);

        // ---- single word ----
        icu_req = 1'b1; icu_biu_addr = 32'h0000_1006; icu_size = 2'b10; icu_type = 4'h5;
        tick();
        check("single pj_req",  {31'd0, pj_req}, 32'd1);
        check("single pj_addr", pj_addr, 32'h0000_1004);
        check("single pj_type", {28'd0, pj_type}, 32'h5);
        check("single pj_size", {30'd0, pj_size}, 32'd2);
        check("single no early ack", {30'd0, biu_icu_ack}, 32'd0);
        pj_ack = 1'b1; pj_data_in = 32'hCAFE_BABE;
        tick();
        check("single ack",  {30'd0, biu_icu_ack}, 32'd1);
        check("single data", biu_data, 32'hCAFE_BABE);
        check("single pj_req drop", {31'd0, pj_req}, 32'd0);
        pj_ack = 1'b0; icu_req = 1'b0;
        tick();
        check("single ack one cycle", {30'd0, biu_icu_ack}, 32'd0);

        // ---- line fill, zero wait, wrap from word 3 ----
        icu_req = 1'b1; icu_biu_addr = 32'h0000_200C; icu_size = 2'b11; icu_type = 4'hA;
        exp_addr[0] = 32'h200C; exp_addr[1] = 32'h2000;
        exp_addr[2] = 32'h2004; exp_addr[3] = 32'h2008;
        tick();
        check("wrap beat0 addr", pj_addr, exp_addr[0]);
        check("wrap pj_type", {28'd0, pj_type}, 32'hA);
        for (int i = 0; i < 4; i++) begin
            pj_ack = 1'b1; pj_data_in = 32'h1000_0000 + i;
            tick();
            check($sformatf("wrap ack%0d", i), {30'd0, biu_icu_ack}, 32'd1);
            check($sformatf("wrap data%0d", i), biu_data, 32'h1000_0000 + i);
            if (i < 3) begin
                check($sformatf("wrap addr%0d", i + 1), pj_addr, exp_addr[i + 1]);
                check($sformatf("wrap req%0d", i + 1), {31'd0, pj_req}, 32'd1);
            end else begin
                check("wrap req drop", {31'd0, pj_req}, 32'd0);
            end
        end
        pj_ack = 1'b0; icu_req = 1'b0;
        tick();
        check("wrap no extra ack", {30'd0, biu_icu_ack}, 32'd0);

        // ---- line fill with two wait states per beat ----
        icu_req = 1'b1; icu_biu_addr = 32'h0000_4004; icu_size = 2'b11;
        exp_addr[0] = 32'h4004; exp_addr[1] = 32'h4008;
        exp_addr[2] = 32'h400C; exp_addr[3] = 32'h4000;
        tick();
        for (int i = 0; i < 4; i++) begin
            pj_ack = 1'b0;
            for (int w = 0; w < 2; w++) begin
                tick();
                check($sformatf("wait addr%0d w%0d", i, w), pj_addr, exp_addr[i]);
                check($sformatf("wait req%0d w%0d", i, w), {31'd0, pj_req}, 32'd1);
                check($sformatf("wait noack%0d w%0d", i, w), {30'd0, biu_icu_ack}, 32'd0);
            end
            pj_ack = 1'b1; pj_data_in = 32'h2000_0000 + i;
            tick();
            check($sformatf("wait ack%0d", i), {30'd0, biu_icu_ack}, 32'd1);
            check($sformatf("wait data%0d", i), biu_data, 32'h2000_0000 + i);
        end
        check("wait req drop", {31'd0, pj_req}, 32'd0);
        pj_ack = 1'b0; icu_req = 1'b0;
        tick();
        check("wait no 5th ack", {30'd0, biu_icu_ack}, 32'd0);

        // ---- error on third beat, then request held high ----
        icu_req = 1'b1; icu_biu_addr = 32'h0000_3000; icu_size = 2'b11;
        tick();
        check("err beat0 addr", pj_addr, 32'h3000);
        pj_ack = 1'b1; pj_data_in = 32'h3333_0000;
        tick();
        check("err ack0", {30'd0, biu_icu_ack}, 32'd1);
        check("err beat1 addr", pj_addr, 32'h3004);
        pj_data_in = 32'h3333_0001;
        tick();
        check("err ack1", {30'd0, biu_icu_ack}, 32'd1);
        check("err beat2 addr", pj_addr, 32'h3008);
        pj_err = 1'b1; pj_data_in = 32'hDEAD_BEEF;
        tick();
        check("err ack10", {30'd0, biu_icu_ack}, 32'd2);
        check("err data zero", biu_data, 32'd0);
        check("err req drop", {31'd0, pj_req}, 32'd0);
        pj_ack = 1'b0; pj_err = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("held no req%0d", h), {31'd0, pj_req}, 32'd0);
            check($sformatf("held no ack%0d", h), {30'd0, biu_icu_ack}, 32'd0);
        end
        icu_req = 1'b0;
        tick();
        check("held released", {31'd0, pj_req}, 32'd0);
        icu_req = 1'b1; icu_biu_addr = 32'h0000_5008; icu_size = 2'b10;
        tick();
        check("held new req", {31'd0, pj_req}, 32'd1);
        check("held new addr", pj_addr, 32'h5008);
        pj_ack = 1'b1; pj_data_in = 32'h5555_AAAA;
        tick();
        check("held new ack", {30'd0, biu_icu_ack}, 32'd1);
        check("held new data", biu_data, 32'h5555_AAAA);
        pj_ack = 1'b0; icu_req = 1'b0;
        tick();

        // ---- asynchronous reset during third beat ----
        icu_req = 1'b1; icu_biu_addr = 32'h0000_6000; icu_size = 2'b11; icu_type = 4'h7;
        tick();
        pj_ack = 1'b1; pj_data_in = 32'h6666_0000;
        tick();
        tick();
        check("rst beat2 addr", pj_addr, 32'h6008);
        pj_ack = 1'b0;
        #2;
        reset_l = 1'b0;
        #1;
        check_reset_outputs("async rst");
        icu_req = 1'b0;
        tick();
        reset_l = 1'b1;
        tick();
        check("post rst no ack", {30'd0, biu_icu_ack}, 32'd0);
        check("post rst no req", {31'd0, pj_req}, 32'd0);
        tick();
        check("post rst idle", {31'd0, pj_req}, 32'd0);
        icu_req = 1'b1; icu_biu_addr = 32'h0000_7000; icu_size = 2'b10;
        tick();
        check("post rst addr", pj_addr, 32'h7000);
        check("post rst req", {31'd0, pj_req}, 32'd1);
        pj_ack = 1'b1; pj_data_in = 32'h7777_1234;
        tick();
        check("post rst ack", {30'd0, biu_icu_ack}, 32'd1);
        check("post rst data", biu_data, 32'h7777_1234);
        pj_ack = 1'b0; icu_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/biu_ifetch.md
# biu_ifetch

Instruction-fetch side of the bus interface unit: sits directly upstream of the instruction cache unit. It accepts the ICU miss/non-cacheable request (`icu_req`, `icu_biu_addr`, `icu_type`, `icu_size`), runs it as one or more word beats on the memory bus, and returns each word to the ICU on `biu_data` qualified by `biu_icu_ack`. Line fills are issued critical-word-first with wrap inside the 16-byte line; bus errors terminate the transaction.

## Interface
- No parameters; widths are fixed.
- clk  in  1  core clock; all state on rising edge.
- reset_l  in  1  reset, asynchronous and active-low.
- icu_req  in  1  ICU fetch request, level; held until final ack seen.
- icu_biu_addr  in  32  fetch byte address.
- icu_type  in  4  transaction type; passed to `pj_type` unchanged.
- icu_size  in  2  2'b10 = single word, 2'b11 = 4-word line; other codes treated as single word.
- biu_data  out  32  returned word, valid while `biu_icu_ack` != 0.
- biu_icu_ack  out  2  2'b01 = word valid, 2'b10 = bus error (transaction ends), 2'b11 never driven.
- pj_req  out  1  memory beat request, held until `pj_ack`.
- pj_addr  out  32  word address of current beat, [1:0] = 0.
- pj_type  out  4  latched `icu_type`.
- pj_size  out  2  always 2'b10 (word beat).
- pj_ack  in  1  beat complete; `pj_data_in`/`pj_err` valid this cycle.
- pj_data_in  in  32  beat read data.
- pj_err  in  1  beat error, qualified by `pj_ack`.

## Operation
- State machine IDLE, BUSY, REL.
- IDLE: `icu_req`=1 → latch addr, type, size; beat counter `cnt`=0; remaining beats `rem` = 3 (line) or 0 (single); go BUSY.
- BUSY: `pj_req`=1, `pj_addr` = {addr[31:4], addr[3:2]+cnt mod 4, 2'b00}; for single, {addr[31:2],2'b00}.
- `pj_ack`=1, `pj_err`=0: register data; ack=01 next cycle; if `rem`=0 go REL, else `cnt`++, `rem`--, stay BUSY.
- `pj_ack`=1, `pj_err`=1: ack=10 next cycle with `biu_data`=0; skip remaining beats; go REL.
- REL: `pj_req`=0; go IDLE only after sampling `icu_req`=0 (prevents re-issue on a stale held request).
- ICU inputs ignored in BUSY and REL; latched values govern whole transaction.
- `pj_ack` with `pj_req`=0 ignored.
- `icu_req` dropped during BUSY: transaction still completes (no abort path); acks still returned.

## Timing
- Reset (async assert): state IDLE; `pj_req`=0, `pj_addr`=0, `pj_type`=0, `pj_size`=2'b10, `biu_icu_ack`=0, `biu_data`=0; in-flight transaction discarded. Deassert synchronous to clk.
- All outputs registered.
- `icu_req` sampled in cycle N (IDLE) → `pj_req`/`pj_addr` valid N+1.
- `pj_ack` in cycle K → `biu_icu_ack`/`biu_data` in K+1 for exactly one cycle; next `pj_addr` in K+1 with `pj_req` continuously high (no bubble between beats).
- Zero-wait memory line fill: beats at N+1..N+4, acks at N+2..N+5, `pj_req` low N+5.
- Wait states: `pj_req`/`pj_addr` stable until `pj_ack`.
- Earliest next acceptance: REL entered at K+1; IDLE at K+2 if `icu_req`=0 at K+1; next request sampled K+2 at earliest.
- Wrap: addr[3:2]=3 → beat order 3,0,1,2; addr[31:4] never changes in a fill.

## Test plan
- Single word: req addr 0x0000_1006, size 10, zero-wait, data 0xCAFEBABE → `pj_addr`=0x0000_1004 one beat; ack 01 with 0xCAFEBABE one cycle after `pj_ack`; `pj_req` drops.
- Line fill wrap: addr 0x0000_200C, size 11, zero-wait → `pj_addr` 0x200C,0x2000,0x2004,0x2008 on consecutive cycles; four 01 acks back-to-back, data in same order.
- Wait states: line fill with 2 idle cycles before each `pj_ack` → `pj_addr` held stable, exactly 4 acks, each one cycle after its `pj_ack`.
- Error mid-burst: `pj_err` on beat 2 of fill at 0x3000 → acks 01,01,10; no 4th beat; `pj_req` low after error beat.
- Held request: `icu_req` kept high 3 cycles after final ack → no new `pj_req` until `icu_req` seen low, then new request accepted normally.
- Reset mid-fill: assert `reset_l`=0 during beat 2 → all outputs reset immediately; after release, idle with no spurious ack; new request works.
